// File: rtl/sid_bus_pkg.sv
// Shared types and constants for the SID register-write master.
package sid_bus_pkg;

    localparam int SID_ADDR_W = 5;
    localparam int SID_DATA_W = 8;
    localparam int PHASE_W    = 4;

    // One queued register write
    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sid_req_t;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } sid_wr_state_e;

    // SID register map
    localparam logic [SID_ADDR_W-1:0] SID_V1_FREQ_LO = 5'h00;
    localparam logic [SID_ADDR_W-1:0] SID_V1_FREQ_HI = 5'h01;
    localparam logic [SID_ADDR_W-1:0] SID_V1_PW_LO   = 5'h02;
    localparam logic [SID_ADDR_W-1:0] SID_V1_PW_HI   = 5'h03;
    localparam logic [SID_ADDR_W-1:0] SID_V1_CTRL    = 5'h04;
    localparam logic [SID_ADDR_W-1:0] SID_V1_AD      = 5'h05;
    localparam logic [SID_ADDR_W-1:0] SID_V1_SR      = 5'h06;
    localparam logic [SID_ADDR_W-1:0] SID_V2_FREQ_LO = 5'h07;
    localparam logic [SID_ADDR_W-1:0] SID_V3_FREQ_LO = 5'h0E;
    localparam logic [SID_ADDR_W-1:0] SID_FC_LO      = 5'h15;
    localparam logic [SID_ADDR_W-1:0] SID_FC_HI      = 5'h16;
    localparam logic [SID_ADDR_W-1:0] SID_RES_FILT   = 5'h17;
    localparam logic [SID_ADDR_W-1:0] SID_MODE_VOL   = 5'h18;

    // Phase counter load value: a phase of N cycles counts N-1 down to 0
    function automatic logic [PHASE_W-1:0] phase_load(input int unsigned cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// Synchronous request FIFO with show-ahead read; pointers carry an extra wrap bit.
module sid_wr_fifo
    import sid_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  sid_req_t wdata_i,
    input  logic     pop_i,
    output sid_req_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    sid_req_t         mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    // A pop frees the head slot, so a push alongside it is safe even when full
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[IDX_W-1:0]];

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/sid_bus_writer.sv
// Buffers SID register writes and replays them with setup/strobe/hold timing.
module sid_bus_writer
    import sid_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SID_ADDR_W-1:0] req_addr,
    input  logic [SID_DATA_W-1:0] req_data,
    output logic [SID_DATA_W-1:0] bus_data,
    output logic [SID_ADDR_W-1:0] bus_addr,
    output logic                  bus_we,
    output logic                  busy,
    output logic [15:0]           wr_count
);

    localparam logic [PHASE_W-1:0] SetupLd  = phase_load(SETUP_CYC);
    localparam logic [PHASE_W-1:0] StrobeLd = phase_load(STROBE_CYC);
    localparam logic [PHASE_W-1:0] HoldLd   = phase_load(HOLD_CYC);

    sid_wr_state_e         state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [SID_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [SID_DATA_W-1:0] bus_data_q, bus_data_d;
    logic                  bus_we_q, bus_we_d;
    logic [15:0]           wr_count_q, wr_count_d;

    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;
    sid_req_t fifo_wdata;
    sid_req_t fifo_head;

    assign fifo_wdata = '{addr: req_addr, data: req_data};
    assign fifo_push  = req_valid && req_ready;
    assign req_ready  = !fifo_full;

    sid_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Write sequencer: pop into SETUP, count down each phase, chain HOLD straight into SETUP
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_we_d   = bus_we_q;
        wr_count_d = wr_count_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    bus_addr_d = fifo_head.addr;
                    bus_data_d = fifo_head.data;
                    phase_d    = SetupLd;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (phase_q == '0) begin
                    bus_we_d = 1'b1;
                    phase_d  = StrobeLd;
                    state_d  = StStrobe;
                end else begin
                    phase_d = phase_q - PHASE_W'(1);
                end
            end
            StStrobe: begin
                if (phase_q == '0) begin
                    bus_we_d   = 1'b0;
                    wr_count_d = wr_count_q + 16'd1;
                    phase_d    = HoldLd;
                    state_d    = StHold;
                end else begin
                    phase_d = phase_q - PHASE_W'(1);
                end
            end
            StHold: begin
                if (phase_q == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        bus_addr_d = fifo_head.addr;
                        bus_data_d = fifo_head.data;
                        phase_d    = SetupLd;
                        state_d    = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    phase_d = phase_q - PHASE_W'(1);
                end
            end
            default: begin
                bus_we_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    // Sequencer state and registered bus outputs; reset cuts the strobe at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_we_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_we_q   <= bus_we_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus_addr = bus_addr_q;
    assign bus_data = bus_data_q;
    assign bus_we   = bus_we_q;
    assign wr_count = wr_count_q;
    assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_sid_bus_writer.sv
// Bench for sid_bus_writer: directed and random traffic against a queue/timestamp model.
module tb_sid_bus_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cur_valid;
    logic [4:0]  req_addr;
    logic [7:0]  req_data;
    int          sel;

    logic        valid_a, ready_a, we_a, busy_a;
    logic [7:0]  data_a;
    logic [4:0]  addr_a;
    logic [15:0] cnt_a;
    logic        valid_b, ready_b, we_b, busy_b;
    logic [7:0]  data_b;
    logic [4:0]  addr_b;
    logic [15:0] cnt_b;

    always #5 clk = ~clk;

    assign valid_a = (sel == 0) && cur_valid;
    assign valid_b = (sel == 1) && cur_valid;

    sid_bus_writer dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (valid_a),
        .req_ready (ready_a),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .bus_data  (data_a),
        .bus_addr  (addr_a),
        .bus_we    (we_a),
        .busy      (busy_a),
        .wr_count  (cnt_a)
    );

    sid_bus_writer #(
        .FIFO_DEPTH (4),
        .SETUP_CYC  (3),
        .STROBE_CYC (1),
        .HOLD_CYC   (2)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (valid_b),
        .req_ready (ready_b),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .bus_data  (data_b),
        .bus_addr  (addr_b),
        .bus_we    (we_b),
        .busy      (busy_b),
        .wr_count  (cnt_b)
    );

    // Reference model: pending queue plus timestamps of the write currently on the bus
    int          t;
    int          s_c, t_c, h_c, d_c;
    logic [12:0] mq[$];
    int          nf;
    int          cs;
    logic [4:0]  ea;
    logic [7:0]  ed;
    logic [15:0] ecnt;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        t    = 0;
        nf   = 0;
        cs   = -1000;
        ea   = '0;
        ed   = '0;
        ecnt = '0;
    endtask

    task automatic check_outputs();
        logic we_e;
        logic busy_e;
        logic rdy_e;
        we_e   = (t >= cs + s_c) && (t < cs + s_c + t_c);
        busy_e = (mq.size() > 0) || (t < nf);
        rdy_e  = (mq.size() < d_c);
        chk("bus_we",   (sel == 0) ? we_a : we_b, we_e);
        chk("bus_addr", (sel == 0) ? addr_a : addr_b, ea);
        chk("bus_data", (sel == 0) ? data_a : data_b, ed);
        chk("wr_count", (sel == 0) ? cnt_a : cnt_b, ecnt);
        chk("busy",     (sel == 0) ? busy_a : busy_b, busy_e);
        chk("req_ready", (sel == 0) ? ready_a : ready_b, rdy_e);
    endtask

    // One clock: decide acceptance from model occupancy, advance model, compare
    task automatic step(output bit acc);
        acc = cur_valid && (mq.size() < d_c);
        @(posedge clk);
        #1;
        t++;
        if (t == cs + s_c + t_c) ecnt++;
        if (mq.size() > 0 && t >= nf) begin
            {ea, ed} = mq.pop_front();
            cs = t;
            nf = t + s_c + t_c + h_c;
        end
        if (acc) mq.push_back({req_addr, req_data});
        check_outputs();
    endtask

    task automatic do_reset();
        cur_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_one(input logic [4:0] a, input logic [7:0] d);
        bit acc;
        bit done;
        done = 1'b0;
        cur_valid = 1'b1;
        req_addr = a;
        req_data = d;
        for (int i = 0; i < 60 && !done; i++) begin
            step(acc);
            done = acc;
        end
        n_checks++;
        assert (done) else begin
            n_err++;
            $error("FAIL push_timeout observed=0 expected=1");
        end
        cur_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        bit done;
        cur_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(acc);
            done = (mq.size() == 0) && (t >= nf);
        end
        n_checks++;
        assert (done) else begin
            n_err++;
            $error("FAIL drain_timeout observed=0 expected=1");
        end
    endtask

    task automatic run_random(input int n, input int pct);
        bit acc;
        acc = 1'b1;
        cur_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!cur_valid || acc) begin
                cur_valid = ($urandom_range(0, 99) < pct);
                req_addr = 5'($urandom_range(0, 31));
                req_data = 8'($urandom_range(0, 255));
            end
            step(acc);
        end
        cur_valid = 1'b0;
    endtask

    task automatic run_directed();
        bit acc;
        // Single write to the volume register
        push_one(5'h18, 8'h0F);
        drain();
        // Burst of six with valid held; ready must drop once four are queued
        cur_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_addr = 5'(k + 1);
            req_data = 8'(8'hA0 + k);
            acc = 1'b0;
            for (int i = 0; i < 60 && !acc; i++) step(acc);
        end
        cur_valid = 1'b0;
        drain();
        chk("burst_count", (sel == 0) ? cnt_a : cnt_b, 16'd7);
    endtask

    initial begin
        bit acc;
        sel = 0;
        cur_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        s_c = 1; t_c = 2; h_c = 1; d_c = 4;
        do_reset();
        run_directed();
        run_random(150, 60);
        drain();
        run_random(100, 95);
        drain();

        // Counter wrap: preload 0xFFFF, one more write rolls to zero
        force dut_a.wr_count_q = 16'hFFFF;
        ecnt = 16'hFFFF;
        step(acc);
        release dut_a.wr_count_q;
        push_one(5'h04, 8'h41);
        drain();
        chk("wrap", cnt_a, 16'h0000);

        // Reset in the middle of a strobe with two requests still queued
        do_reset();
        push_one(5'h05, 8'h11);
        cur_valid = 1'b1;
        req_addr = 5'h06;
        req_data = 8'h22;
        step(acc);
        req_addr = 5'h07;
        req_data = 8'h33;
        step(acc);
        cur_valid = 1'b0;
        for (int i = 0; i < 10 && !((t >= cs + s_c) && (t < cs + s_c + t_c)); i++) step(acc);
        chk("pre_abort_we", we_a, 1'b1);
        chk("pre_abort_queued", 32'(mq.size()), 32'd2);
        do_reset();
        for (int i = 0; i < 20; i++) step(acc);

        // Second configuration: 3/1/2 timing
        sel = 1;
        s_c = 3; t_c = 1; h_c = 2; d_c = 4;
        do_reset();
        run_directed();
        run_random(150, 70);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
